// File: rtl/loader_pkg.sv
// Shared types and default widths for the boot-time program loader.
package loader_pkg;

    localparam int LOADER_ADDR_W = 16;
    localparam int LOADER_DATA_W = 8;

    typedef enum logic [2:0] {
        LEN_H,
        LEN_L,
        DATA,
        WRITE,
        CHK,
        RUN,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Holds the CPU in reset while a length/payload/checksum stream is written into RAM,
// then hands the RAM bus to the CPU as a zero-latency pass-through.
module program_loader
    import loader_pkg::*;
#(
    parameter int                ADDR_W    = LOADER_ADDR_W,
    parameter int                DATA_W    = LOADER_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              boot_req,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic [DATA_W-1:0] cpu_data_in,
    input  logic              cpu_wr_in,
    input  logic              cpu_oe_in,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic [DATA_W-1:0] ram_data_out,
    output logic              ram_wr_out,
    output logic              ram_oe_out,
    output logic              cpu_reset_out,
    output logic              load_done,
    output logic              load_error
);

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       idx_q, idx_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              rx_ready_q, rx_ready_d;
    logic              ram_wr_q, ram_wr_d;
    logic              run_q, run_d;
    logic              error_q, error_d;

    logic              accept;
    logic [15:0]       idx_inc;

    assign accept  = rx_valid && rx_ready_q;
    assign idx_inc = idx_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        case (state_q)
            LEN_H: begin
                if (accept) begin
                    len_d[15:8] = 8'(rx_data);
                    state_d     = LEN_L;
                end
            end
            LEN_L: begin
                if (accept) begin
                    len_d[7:0] = 8'(rx_data);
                    idx_d      = '0;
                    sum_d      = '0;
                    state_d    = ({len_q[15:8], 8'(rx_data)} == 16'd0) ? CHK : DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    wr_addr_d = BASE_ADDR + ADDR_W'(idx_q);
                    wr_data_d = rx_data;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                sum_d   = sum_q + wr_data_q;
                idx_d   = idx_inc;
                state_d = (idx_inc == len_q) ? CHK : DATA;
            end
            CHK: begin
                if (accept) begin
                    state_d = (rx_data == sum_q) ? RUN : ERROR;
                end
            end
            default: begin
            end
        endcase

        // A restart wins over everything, including a byte offered in the same cycle.
        if (boot_req) begin
            state_d   = LEN_H;
            len_d     = '0;
            idx_d     = '0;
            sum_d     = '0;
            wr_addr_d = '0;
            wr_data_d = '0;
        end

        rx_ready_d = (state_d == LEN_H) || (state_d == LEN_L) ||
                     (state_d == DATA)  || (state_d == CHK);
        ram_wr_d   = (state_d == WRITE);
        run_d      = (state_d == RUN);
        error_d    = (state_d == ERROR);
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q    <= LEN_H;
            len_q      <= '0;
            idx_q      <= '0;
            sum_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rx_ready_q <= 1'b1;
            ram_wr_q   <= 1'b0;
            run_q      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rx_ready_q <= rx_ready_d;
            ram_wr_q   <= ram_wr_d;
            run_q      <= run_d;
            error_q    <= error_d;
        end
    end

    // Once running, the CPU owns the RAM bus with no register in the path.
    always_comb begin
        if (run_q) begin
            ram_addr_out = cpu_addr_in;
            ram_data_out = cpu_data_in;
            ram_wr_out   = cpu_wr_in;
            ram_oe_out   = cpu_oe_in;
        end else begin
            ram_addr_out = wr_addr_q;
            ram_data_out = wr_data_q;
            ram_wr_out   = ram_wr_q;
            ram_oe_out   = 1'b0;
        end
    end

    assign rx_ready      = rx_ready_q;
    assign cpu_reset_out = !run_q;
    assign load_done     = run_q;
    assign load_error    = error_q;

endmodule
